// File: rtl/ar_id_guard.sv
// ar_id_guard: AR admission stage that allows one in-flight read per ARID and caps the total outstanding reads.
// The AR is registered toward the reorder buffer, and IDs are freed on completed R beats.
// Optional AR_ID_GUARD_STALL_CNT_EN adds stall_cnt_o, a saturating count of cycles with a blocked valid request.
module ar_id_guard #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ID_WIDTH-1:0]                s_arid_i,
  input  logic                               s_arvalid_i,
  output logic                               s_arready_o,
  output logic [ID_WIDTH-1:0]                m_arid_o,
  output logic                               m_arvalid_o,
  input  logic                               m_arready_i,
  input  logic                               r_done_i,
  input  logic [ID_WIDTH-1:0]                r_done_id_i,
`ifdef AR_ID_GUARD_STALL_CNT_EN
  output logic [31:0]                        stall_cnt_o,
`endif
  output logic [$clog2(2**ID_WIDTH+1)-1:0]   busy_cnt_o
);
  localparam int N  = 2**ID_WIDTH;
  localparam int CW = $clog2(N+1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t              r_state;
  logic                r_arvalid;
  logic [ID_WIDTH-1:0] r_arid;
  logic [N-1:0]        r_busy;
  logic [CW-1:0]       r_cnt;
  logic                w_slot_free;
  logic                w_id_ok;
  logic                w_accept;
  logic                w_free;
  logic [N-1:0]        w_set;
  logic [N-1:0]        w_clr;
  assign w_slot_free = (r_state == EMPTY) || m_arready_i;
  assign w_id_ok     = !r_busy[s_arid_i] && (r_cnt < CW'(MAX_OUTSTANDING));
  assign s_arready_o = w_slot_free && w_id_ok;
  assign w_accept    = s_arvalid_i && s_arready_o;
  assign w_free      = r_done_i && r_busy[r_done_id_i];
  assign m_arvalid_o = r_arvalid;
  assign m_arid_o    = r_arid;
  assign busy_cnt_o  = r_cnt;
  // One-hot set/clear masks for the scoreboard; accept and free never target the same ID
  always_comb begin
    w_set = '0;
    w_clr = '0;
    w_set[s_arid_i]    = w_accept;
    w_clr[r_done_id_i] = w_free;
  end
  // Output register FSM: load on accept, drop on downstream handshake without a new accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_arvalid <= 1'b0;
      r_arid    <= '0;
    end else if (w_accept) begin
      r_state   <= FULL;
      r_arvalid <= 1'b1;
      r_arid    <= s_arid_i;
    end else if (m_arready_i) begin
      r_state   <= EMPTY;
      r_arvalid <= 1'b0;
    end
  end
  // Busy scoreboard and population count; no same-cycle bypass of a freed ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_cnt  <= r_cnt + CW'(w_accept) - CW'(w_free);
    end
  end
`ifdef AR_ID_GUARD_STALL_CNT_EN
  logic [31:0] r_stall;
  assign stall_cnt_o = r_stall;
  // Saturating count of cycles where a valid request is blocked by its ID or the cap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall <= '0;
    else if (s_arvalid_i && !w_id_ok && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
`endif
endmodule
